// File: rtl/regfile_8xn_pkg.sv
// Shared constants for the 8-entry register file: default width, index sizing and a zero word.
package regfile_8xn_pkg;

  localparam int DATA_W  = 32;
  localparam int IDX_W   = 3;
  localparam int REG_CNT = 8;

  localparam logic [DATA_W-1:0] ZERO_WORD = '0;

  // True when a write to idx must be dropped because r0 is hardwired.
  function automatic logic is_zero_reg(input logic [IDX_W-1:0] idx, input bit zero_r0);
    return zero_r0 && (idx == '0);
  endfunction

endpackage

// File: rtl/regfile_8xn_mux.sv
// Generic N-bit 8:1 multiplexer used for the register file read ports.
module mux_8to1 #(
  parameter int N = 32
) (
  input  logic [N-1:0] d0,
  input  logic [N-1:0] d1,
  input  logic [N-1:0] d2,
  input  logic [N-1:0] d3,
  input  logic [N-1:0] d4,
  input  logic [N-1:0] d5,
  input  logic [N-1:0] d6,
  input  logic [N-1:0] d7,
  input  logic [2:0]   S,
  output logic [N-1:0] Y
);

  always_comb begin
    Y = d0;
    unique case (S)
      3'd0: Y = d0;
      3'd1: Y = d1;
      3'd2: Y = d2;
      3'd3: Y = d3;
      3'd4: Y = d4;
      3'd5: Y = d5;
      3'd6: Y = d6;
      3'd7: Y = d7;
      default: Y = d0;
    endcase
  end

endmodule

// File: rtl/regfile_8xn.sv
// 8 x N register file: one synchronous write port, two combinational read ports,
// optional hardwired r0 and optional same-cycle write forwarding.
module regfile_8xn
  import regfile_8xn_pkg::*;
#(
  parameter int N       = DATA_W,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_ena,
  input  logic [IDX_W-1:0]   wr_addr,
  input  logic [N-1:0]       wr_data,
  input  logic [IDX_W-1:0]   rd_addr0,
  output logic [N-1:0]       rd_data0,
  input  logic [IDX_W-1:0]   rd_addr1,
  output logic [N-1:0]       rd_data1,
  output logic [REG_CNT-1:0] written
);

  logic [N-1:0]       regs [REG_CNT];
  logic [REG_CNT-1:0] wr_sel;
  logic [REG_CNT-1:0] written_q;
  logic               wr_live;
  logic [IDX_W-1:0]   rd_addr [2];
  logic [N-1:0]       mux_out [2];

  // A write that actually lands: enabled and not aimed at a hardwired r0.
  assign wr_live = wr_ena && !is_zero_reg(wr_addr, ZERO_R0);

  always_comb begin
    wr_sel = '0;
    if (wr_live) begin
      wr_sel[wr_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++) begin
        regs[i] <= N'(ZERO_WORD);
      end
      written_q <= '0;
    end else begin
      for (int i = 0; i < REG_CNT; i++) begin
        if (wr_sel[i]) begin
          regs[i]      <= wr_data;
          written_q[i] <= 1'b1;
        end
      end
    end
  end

  assign written    = written_q;
  assign rd_addr[0] = rd_addr0;
  assign rd_addr[1] = rd_addr1;

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [N-1:0] val;

    mux_8to1 #(.N(N)) u_mux (
      .d0(regs[0]), .d1(regs[1]), .d2(regs[2]), .d3(regs[3]),
      .d4(regs[4]), .d5(regs[5]), .d6(regs[6]), .d7(regs[7]),
      .S (rd_addr[p]),
      .Y (mux_out[p])
    );

    // Forwarding is blocked during reset; r0 forcing overrides everything.
    always_comb begin
      val = mux_out[p];
      if (BYPASS && !rst && wr_live && (rd_addr[p] == wr_addr)) begin
        val = wr_data;
      end
      if (is_zero_reg(rd_addr[p], ZERO_R0)) begin
        val = '0;
      end
    end
  end

  assign rd_data0 = g_port[0].val;
  assign rd_data1 = g_port[1].val;

endmodule

// File: tb/tb_regfile_8xn.sv
// Scoreboard bench: two register file configurations share stimulus and are
// compared every cycle against an array-based reference model.
module tb_regfile_8xn;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_ena = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [2:0]  rd_addr0 = '0;
  logic [2:0]  rd_addr1 = '0;

  logic [31:0] rd_data0_a, rd_data1_a, rd_data0_b, rd_data1_b;
  logic [7:0]  written_a, written_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // a: hardwired r0, no forwarding.  b: plain r0, forwarding on.
  regfile_8xn #(.N(32), .ZERO_R0(1'b1), .BYPASS(1'b0)) dut_a (
    .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr0(rd_addr0), .rd_data0(rd_data0_a),
    .rd_addr1(rd_addr1), .rd_data1(rd_data1_a),
    .written(written_a)
  );

  regfile_8xn #(.N(32), .ZERO_R0(1'b0), .BYPASS(1'b1)) dut_b (
    .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr0(rd_addr0), .rd_data0(rd_data0_b),
    .rd_addr1(rd_addr1), .rd_data1(rd_data1_b),
    .written(written_b)
  );

  typedef struct {
    string       name;
    logic [31:0] rd0_a, rd1_a, rd0_b, rd1_b;
    logic [7:0]  wr_a, wr_b;
  } expect_t;

  expect_t exp_q[$];

  logic [31:0] mem_a [8];
  logic [31:0] mem_b [8];
  logic [7:0]  wmask_a, wmask_b;
  bit          model_valid = 1'b0;

  function automatic logic [31:0] model_read_a(input logic [2:0] a);
    return (a == 3'd0) ? 32'h0 : mem_a[a];
  endfunction

  function automatic logic [31:0] model_read_b(input logic [2:0] a, input logic r,
                                               input logic we, input logic [2:0] wa,
                                               input logic [31:0] wd);
    if (!r && we && a == wa) return wd;
    return mem_b[a];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Drive one cycle's inputs, queue the expected outputs, then advance the model.
  task automatic applyStimulus(input string name, input logic r, input logic we,
                               input logic [2:0] wa, input logic [31:0] wd,
                               input logic [2:0] ra0, input logic [2:0] ra1);
    expect_t e;
    rst = r; wr_ena = we; wr_addr = wa; wr_data = wd;
    rd_addr0 = ra0; rd_addr1 = ra1;
    if (model_valid) begin
      e.name  = name;
      e.rd0_a = model_read_a(ra0);
      e.rd1_a = model_read_a(ra1);
      e.rd0_b = model_read_b(ra0, r, we, wa, wd);
      e.rd1_b = model_read_b(ra1, r, we, wa, wd);
      e.wr_a  = wmask_a;
      e.wr_b  = wmask_b;
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 8; i++) begin
        mem_a[i] = 32'h0;
        mem_b[i] = 32'h0;
      end
      wmask_a = 8'h00;
      wmask_b = 8'h00;
      model_valid = 1'b1;
    end else if (we) begin
      mem_b[wa] = wd;
      wmask_b[wa] = 1'b1;
      if (wa != 3'd0) begin
        mem_a[wa] = wd;
        wmask_a[wa] = 1'b1;
      end
    end
    #1;
  endtask

  initial begin : monitor
    expect_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput({e.name, ".a.rd0"}, rd_data0_a, e.rd0_a);
        checkOutput({e.name, ".a.rd1"}, rd_data1_a, e.rd1_a);
        checkOutput({e.name, ".a.written"}, {24'h0, written_a}, {24'h0, e.wr_a});
        checkOutput({e.name, ".b.rd0"}, rd_data0_b, e.rd0_b);
        checkOutput({e.name, ".b.rd1"}, rd_data1_b, e.rd1_b);
        checkOutput({e.name, ".b.written"}, {24'h0, written_b}, {24'h0, e.wr_b});
      end
    end
  end

  initial begin : stimulus
    int guard;
    @(posedge clk); #1;
    applyStimulus("init_rst", 1'b1, 1'b0, 3'd0, 32'h0, 3'd0, 3'd0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus("reset_read", 1'b0, 1'b0, 3'd0, 32'h0, 3'(i), 3'(7 - i));
    end

    applyStimulus("wr_r5", 1'b0, 1'b1, 3'd5, 32'hDEADBEEF, 3'd0, 3'd1);
    applyStimulus("rd_r5", 1'b0, 1'b0, 3'd0, 32'h0, 3'd5, 3'd5);

    applyStimulus("wr_r0", 1'b0, 1'b1, 3'd0, 32'h12345678, 3'd1, 3'd2);
    applyStimulus("rd_r0", 1'b0, 1'b0, 3'd0, 32'h0, 3'd0, 3'd0);

    applyStimulus("byp_r3", 1'b0, 1'b1, 3'd3, 32'hA5A5A5A5, 3'd3, 3'd3);
    applyStimulus("rd_r3", 1'b0, 1'b0, 3'd0, 32'h0, 3'd3, 3'd3);

    for (int i = 1; i < 8; i++) begin
      applyStimulus("fill", 1'b0, 1'b1, 3'(i), 32'h11 * i, 3'(i), 3'(i - 1));
    end
    applyStimulus("rst_vs_wr", 1'b1, 1'b1, 3'd2, 32'hFFFFFFFF, 3'd2, 3'd7);
    for (int i = 0; i < 8; i += 2) begin
      applyStimulus("post_rst", 1'b0, 1'b0, 3'd0, 32'h0, 3'(i), 3'(i + 1));
    end

    applyStimulus("b2b_1", 1'b0, 1'b1, 3'd4, 32'h1, 3'd4, 3'd4);
    applyStimulus("b2b_2", 1'b0, 1'b1, 3'd4, 32'h2, 3'd4, 3'd4);
    applyStimulus("b2b_rd", 1'b0, 1'b0, 3'd0, 32'h0, 3'd4, 3'd4);

    for (int n = 0; n < 400; n++) begin
      applyStimulus("rand", ($urandom_range(0, 29) == 0), 1'($urandom),
                    3'($urandom), $urandom, 3'($urandom), 3'($urandom));
    end

    rst = 1'b0; wr_ena = 1'b0;
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain actual=%0d expected=0 pending", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
